vga_timing_gen: RTL

Parametrised VGA raster timing generator, the next generation of the fixed 640x480 controller. It adds configurable geometry, sync polarity, a pixel-clock divider and a programmable output delay. The delay aligns `hsync`/`vsync`/`valid` with the pixel data returned by the frame/tile memory after `mem_addr_gen`'s address lookup. It also emits frame-level strobes (`sof`, `vblank`) and a frame counter, so game logic (ball, board, bricks) can update once per frame.

---
 rtl/vga_pkg.sv | 30 +++
 rtl/vga_delay_line.sv | 44 ++++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg : shared 640x480@60 raster constants, sync polarity codes, helpers
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
   localparam int VGA_MAX_TOTAL = (VGA_H_TOTAL > VGA_V_TOTAL) ? VGA_H_TOTAL : VGA_V_TOTAL;

   localparam bit SYNC_ACT_LOW  = 1'b0;
   localparam bit SYNC_ACT_HIGH = 1'b1;

   // Maps a logical "sync asserted" flag onto the physical pin level.
   function automatic logic sync_level(input logic i_on, input logic i_pol);
      return i_on ? i_pol : ~i_pol;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_delay_line : enable-gated shift register, synchronous reset to RST_VAL
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_delay_line #(
   parameter int               DEPTH   = 2,
   parameter int               WIDTH   = 3,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   generate
      if (DEPTH == 0) begin : g_bypass
         logic w_unused;
         assign w_unused = &{1'b0, pclk, reset, i_en};
         assign o_q      = i_d;
      end else begin : g_shift
         logic [WIDTH-1:0] r_stage [DEPTH];

         always_ff @(posedge pclk) begin
            if (reset) begin
               for (int i = 0; i < DEPTH; i++) begin
                  r_stage[i] <= RST_VAL;
               end
            end else if (i_en) begin
               r_stage[0] <= i_d;
               for (int i = 1; i < DEPTH; i++) begin
                  r_stage[i] <= r_stage[i-1];
               end
            end
         end

         assign o_q = r_stage[DEPTH-1];
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_gen : parametrised VGA raster counters, delayed syncs, frame strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter bit HS_POL   = SYNC_ACT_LOW,
   parameter bit VS_POL   = SYNC_ACT_LOW,
   parameter int CLK_DIV  = 1,
   parameter int PIPE_DLY = 2,
   parameter int CNT_W    = $clog2(VGA_MAX_TOTAL),
   parameter int FRAME_W  = 16
) (
   input  logic               pclk,
   input  logic               reset,
   output logic               pix_tick,
   output logic [CNT_W-1:0]   h_cnt,
   output logic [CNT_W-1:0]   v_cnt,
   output logic               active,
   output logic               hsync,
   output logic               vsync,
   output logic               valid,
   output logic               sof,
   output logic               vblank,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]   c_H_LAST     = CNT_W'(c_H_TOTAL - 1);
   localparam logic [CNT_W-1:0]   c_V_LAST     = CNT_W'(c_V_TOTAL - 1);
   localparam logic [CNT_W-1:0]   c_H_ACT      = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0]   c_V_ACT      = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0]   c_V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0]   c_HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0]   c_HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0]   c_VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0]   c_VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Idle pattern of the {hsync, vsync, active} bundle.
   localparam logic [2:0] c_IDLE = {~HS_POL, ~VS_POL, 1'b0};

   logic [c_DIV_W-1:0] r_div;
   logic [CNT_W-1:0]   r_h_cnt;
   logic [CNT_W-1:0]   r_v_cnt;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic [2:0]         r_sync_out;

   logic       w_tick;
   logic       w_h_last;
   logic       w_v_last;
   logic       w_active;
   logic       w_hs_raw;
   logic       w_vs_raw;
   logic [2:0] w_dly_out;

   // Gated by reset so no strobe leaks out while the counters are being cleared.
   assign w_tick   = ~reset && (r_div == c_DIV_LAST);
   assign w_h_last = (r_h_cnt == c_H_LAST);
   assign w_v_last = (r_v_cnt == c_V_LAST);
   assign w_active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
   assign w_hs_raw = sync_level((r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST), HS_POL);
   assign w_vs_raw = sync_level((r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST), VS_POL);

   always_ff @(posedge pclk) begin
      if (reset) begin
         r_div       <= '0;
         r_h_cnt     <= '0;
         r_v_cnt     <= '0;
         r_frame_cnt <= '0;
      end else begin
         r_div <= (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;
         if (w_tick) begin
            r_h_cnt <= w_h_last ? '0 : r_h_cnt + 1'b1;
            if (w_h_last) begin
               r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
               if (w_v_last) begin
                  r_frame_cnt <= r_frame_cnt + 1'b1;
               end
            end
         end
      end
   end

   vga_delay_line #(
      .DEPTH   (PIPE_DLY),
      .WIDTH   (3),
      .RST_VAL (c_IDLE)
   ) u_delay (
      .pclk  (pclk),
      .reset (reset),
      .i_en  (w_tick),
      .i_d   ({w_hs_raw, w_vs_raw, w_active}),
      .o_q   (w_dly_out)
   );

   // Final retiming stage runs every pclk so the pins are glitch-free.
   always_ff @(posedge pclk) begin
      if (reset) begin
         r_sync_out <= c_IDLE;
      end else begin
         r_sync_out <= w_dly_out;
      end
   end

   assign pix_tick  = w_tick;
   assign h_cnt     = r_h_cnt;
   assign v_cnt     = r_v_cnt;
   assign active    = w_active;
   assign hsync     = r_sync_out[2];
   assign vsync     = r_sync_out[1];
   assign valid     = r_sync_out[0];
   assign sof       = w_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
   assign vblank    = w_tick && w_h_last && (r_v_cnt == c_V_ACT_LAST);
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire
